collision_scheduler: RTL and testbench
======================================

// Module: collision_scheduler
// PURPOSE
//  Per-frame collision controller for both bikes. On each frame_start (vblank), owns the shared
//  trail-RAM read/write port, probes the two "front corner" pixels of each bike, and flags
//  crashes (trail hit or screen wall). It then stamps each surviving bike's head pixel into the
//  trail RAM. Outside its busy window the port is passed through to the VGA scan address.
// PARAMETERS
//  SCREEN_W    640  pixels per row (address = y*SCREEN_W + x)
//  SCREEN_H    480  rows
//  PROBE_AHEAD 16   probe distance ahead of bike centre along heading, pixels
//  PROBE_SIDE  5    probe lateral offset either side of heading, pixels
//  ADDR_W      19   trail RAM address width
//  DATA_W      4    trail RAM data width (0 = empty cell, else owner colour)
// PORTS
//  clock        in  1       system clock, all state on rising edge
//  reset        in  1       synchronous, active-high
//  frame_start  in  1       1-cycle pulse at vblank start
//  new_round    in  1       1-cycle pulse: clears crash1/2, game_over, winner, overrun
//  bike1_x      in  10      bike 1 centre column;  bike1_y in 9: centre row
//  bike1_orient in  2       0 up, 1 left, 2 down, 3 right
//  bike1_color  in  DATA_W  value stamped for bike 1 (nonzero)
//  bike2_x/_y/_orient/_color  same for bike 2
//  vga_addr     in  ADDR_W  scan address, forwarded when idle
//  ram_addr     out ADDR_W  trail RAM address (muxed)
//  ram_rdata    in  DATA_W  trail RAM read data, 1-cycle latency
//  ram_we       out 1       trail RAM write enable;  ram_wdata out DATA_W
//  busy         out 1       scheduler owns RAM port
//  done         out 1       1-cycle pulse at end of frame sequence
//  crash1/crash2 out 1      sticky crash flags
//  game_over    out 1       sticky, crash1|crash2
//  winner       out 2       0 none/draw, 1 bike 1, 2 bike 2; valid when game_over
//  overrun      out 1       sticky: frame_start arrived while busy
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; ram_addr = vga_addr (combinational mux).
//  - FSM: IDLE -> LATCH -> {ISS,CHK} x4 (P1A,P1B,P2A,P2B) -> WR1 -> WR2 -> DONE -> IDLE.
//  - IDLE: frame_start & !game_over -> LATCH. frame_start while game_over is ignored.
//  - LATCH (frame_start+1): register x/y/orient/colour of both bikes; compute 4 probe coords
//    and addresses. Probe offsets by orient (dx,dy): up (-S,-A),(+S,-A); left (-A,-S),(-A,+S);
//    down (+S,+A),(-S,+A); right (+A,-S),(+A,+S), with A = PROBE_AHEAD, S = PROBE_SIDE.
//  - Coordinates are computed as signed 11-bit. oob = px<0 | px>=SCREEN_W | py<0 | py>=SCREEN_H.
//    Address = py*640+px, computed as (py<<9)+(py<<7)+px and truncated to ADDR_W.
//  - ISS: drive probe address. CHK (next cycle): hit = oob | (ram_rdata != 0). Any hit on
//    P1A/P1B sets crash1; any hit on P2A/P2B sets crash2. An oob probe still spends its 2 cycles.
//  - WR1: if !crash1, ram_we=1, addr=bike1 centre, wdata=bike1_color; else ram_we=0.
//    WR2: same for bike 2. Stamping after probing, so a bike never hits its own new head.
//  - DONE: done=1 for one cycle. Status updates at this edge: game_over |= crash1|crash2;
//    winner = (c1&!c2)?2 : (c2&!c1)?1 : 0, written only on the first transition to game_over.
//  - Fixed timing: done is high in cycle frame_start+12; busy is high in cycles +1..+12.
//  - While busy: ram_addr = scheduler address, vga_addr is ignored, and VGA reads see stale data
//    (acceptable in vblank). frame_start while busy sets overrun and is dropped.
//  - new_round: clears the sticky flags and winner. If it coincides with a DONE that sets a
//    crash, new_round wins. It does not abort an in-flight sequence.
//  - Reset mid-sequence: the next cycle is IDLE with ram_we=0, and there is no partial write.
// STRUCTURE
//  - lightbike_pkg: ORIENT_UP/LEFT/DOWN/RIGHT codes, SCREEN_W/H, PROBE_AHEAD/SIDE, state enum.
//  - Sub-module probe_addr_gen: combinational (x,y,orient,side_sel) -> (addr, oob).
//    Instantiated 4x, or 1x muxed by state.
// TESTING
//  1 Empty RAM, bike1 (320,240) up, bike2 (100,100) right, frame_start -> reads at 320-5+224*640
//    and 325+224*640. done at +12; RAM[240*640+320]=c1, RAM[100*640+100]=c2; no crash.
//  2 RAM[325+224*640]=3, bike1 up at (320,240) -> crash1=1, game_over=1, winner=2, bike1 not
//    stamped, bike2 stamped.
//  3 Walls: bike1 up at (320,10) and bike2 left at (3,200), same frame -> both crash, winner=0.
//  4 frame_start again at +5 -> overrun=1, sequence still finishes with done at +12.
//    After game_over, frame_start -> busy stays 0.
//  5 reset at cycle +11 (WR2) -> ram_we=0 next cycle, all flags 0, ram_addr==vga_addr.
//  6 new_round in the same cycle as a crash-setting DONE -> game_over=0, winner=0.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared constants, encodings and pixel-address helper for the light-bike collision logic.
package lightbike_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PROBE_AHEAD = 16;
    localparam int PROBE_SIDE  = 5;
    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 4;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int C_W         = 11;

    typedef enum logic [1:0] {
        ORIENT_UP    = 2'd0,
        ORIENT_LEFT  = 2'd1,
        ORIENT_DOWN  = 2'd2,
        ORIENT_RIGHT = 2'd3
    } orient_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ISS,
        ST_CHK,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        orient_t           orient;
        logic [DATA_W-1:0] color;
    } bike_t;

    // y*640 + x as shift-adds; out-of-range coordinates simply wrap.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic signed [C_W-1:0] px,
                                                     input logic signed [C_W-1:0] py);
        logic signed [ADDR_W+1:0] px_w;
        logic signed [ADDR_W+1:0] py_w;
        logic signed [ADDR_W+1:0] sum;
        px_w = (ADDR_W+2)'(px);
        py_w = (ADDR_W+2)'(py);
        sum  = (py_w <<< 9) + (py_w <<< 7) + px_w;
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// Combinational probe-point generator: one front corner of a bike -> RAM address and wall flag.
module probe_addr_gen
    import lightbike_pkg::*;
(
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  orient_t           orient,
    input  logic              side_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam logic signed [C_W-1:0] A     = C_W'(PROBE_AHEAD);
    localparam logic signed [C_W-1:0] S     = C_W'(PROBE_SIDE);
    localparam logic signed [C_W-1:0] W_LIM = C_W'(SCREEN_W);
    localparam logic signed [C_W-1:0] H_LIM = C_W'(SCREEN_H);

    logic signed [C_W-1:0] dx;
    logic signed [C_W-1:0] dy;
    logic signed [C_W-1:0] px;
    logic signed [C_W-1:0] py;

    always_comb begin
        dx = '0;
        dy = '0;
        unique case (orient)
            ORIENT_UP:    begin dx = side_sel ? S : -S; dy = -A; end
            ORIENT_LEFT:  begin dx = -A; dy = side_sel ? S : -S; end
            ORIENT_DOWN:  begin dx = side_sel ? -S : S; dy = A; end
            ORIENT_RIGHT: begin dx = A; dy = side_sel ? S : -S; end
            default:      ;
        endcase
        px = $signed({1'b0, x}) + dx;
        py = $signed({2'b0, y}) + dy;
    end

    assign oob  = px[C_W-1] || (px >= W_LIM) || py[C_W-1] || (py >= H_LIM);
    assign addr = pixel_addr(px, py);

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: probes four corner pixels, flags crashes, stamps surviving
// bike heads, and otherwise forwards the VGA scan address to the trail RAM.
module collision_scheduler
    import lightbike_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              new_round,
    input  logic [X_W-1:0]    bike1_x,
    input  logic [Y_W-1:0]    bike1_y,
    input  logic [1:0]        bike1_orient,
    input  logic [DATA_W-1:0] bike1_color,
    input  logic [X_W-1:0]    bike2_x,
    input  logic [Y_W-1:0]    bike2_y,
    input  logic [1:0]        bike2_orient,
    input  logic [DATA_W-1:0] bike2_color,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              crash1,
    output logic              crash2,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              overrun
);

    state_t            state_reg, state_next;
    logic [1:0]        probe_idx_reg;
    bike_t             bike_reg [2];
    logic              crash1_reg, crash2_reg, game_over_reg, overrun_reg;
    logic [1:0]        winner_reg;
    logic [ADDR_W-1:0] probe_addr [4];
    logic              probe_oob  [4];
    logic [ADDR_W-1:0] centre_addr [2];
    logic              hit;

    // Probes 0/1 belong to bike 1, probes 2/3 to bike 2.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_probe
            probe_addr_gen u_probe (
                .x        (bike_reg[gi/2].x),
                .y        (bike_reg[gi/2].y),
                .orient   (bike_reg[gi/2].orient),
                .side_sel (1'(gi % 2)),
                .addr     (probe_addr[gi]),
                .oob      (probe_oob[gi])
            );
        end
        for (gi = 0; gi < 2; gi++) begin : g_centre
            assign centre_addr[gi] = pixel_addr({1'b0, bike_reg[gi].x}, {2'b0, bike_reg[gi].y});
        end
    endgenerate

    assign hit = probe_oob[probe_idx_reg] || (ram_rdata != '0);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (frame_start && !game_over_reg) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_ISS;
            ST_ISS:   state_next = ST_CHK;
            ST_CHK:   state_next = (probe_idx_reg == 2'd3) ? ST_WR1 : ST_ISS;
            ST_WR1:   state_next = ST_WR2;
            ST_WR2:   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Write enable is masked by reset so an aborted sequence never completes a stamp.
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_DONE);
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = probe_addr[probe_idx_reg];
        unique case (state_reg)
            ST_IDLE: ram_addr = vga_addr;
            ST_WR1: begin
                ram_addr  = centre_addr[0];
                ram_wdata = bike_reg[0].color;
                ram_we    = !crash1_reg && !reset;
            end
            ST_WR2: begin
                ram_addr  = centre_addr[1];
                ram_wdata = bike_reg[1].color;
                ram_we    = !crash2_reg && !reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            probe_idx_reg <= '0;
            bike_reg[0]   <= '0;
            bike_reg[1]   <= '0;
            crash1_reg    <= 1'b0;
            crash2_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            winner_reg    <= 2'd0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_LATCH) begin
                bike_reg[0]   <= '{bike1_x, bike1_y, orient_t'(bike1_orient), bike1_color};
                bike_reg[1]   <= '{bike2_x, bike2_y, orient_t'(bike2_orient), bike2_color};
                probe_idx_reg <= '0;
            end
            if (state_reg == ST_CHK) begin
                probe_idx_reg <= probe_idx_reg + 2'd1;
                if (hit && !probe_idx_reg[1]) crash1_reg <= 1'b1;
                if (hit &&  probe_idx_reg[1]) crash2_reg <= 1'b1;
            end
            if (frame_start && state_reg != ST_IDLE) overrun_reg <= 1'b1;
            if (state_reg == ST_DONE && (crash1_reg || crash2_reg)) begin
                game_over_reg <= 1'b1;
                if (!game_over_reg)
                    winner_reg <= (crash1_reg && !crash2_reg) ? 2'd2 :
                                  (crash2_reg && !crash1_reg) ? 2'd1 : 2'd0;
            end
            // Placed last so a new round overrides any same-cycle crash update.
            if (new_round) begin
                crash1_reg    <= 1'b0;
                crash2_reg    <= 1'b0;
                game_over_reg <= 1'b0;
                winner_reg    <= 2'd0;
                overrun_reg   <= 1'b0;
            end
        end
    end

    assign crash1    = crash1_reg;
    assign crash2    = crash2_reg;
    assign game_over = game_over_reg;
    assign winner    = winner_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: stimulus queues expected writes and end-of-frame
// status; independent monitors compare them when the DUT writes or pulses done.
module tb_collision_scheduler;
    import lightbike_pkg::*;

    logic        clock = 1'b0;
    logic        reset, frame_start, new_round;
    logic [9:0]  bike1_x, bike2_x;
    logic [8:0]  bike1_y, bike2_y;
    logic [1:0]  bike1_orient, bike2_orient;
    logic [3:0]  bike1_color, bike2_color;
    logic [18:0] vga_addr, ram_addr;
    logic [3:0]  ram_rdata = 4'd0;
    logic [3:0]  ram_wdata;
    logic        ram_we, busy, done, crash1, crash2, game_over, overrun;
    logic [1:0]  winner;

    collision_scheduler dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .new_round(new_round),
        .bike1_x(bike1_x), .bike1_y(bike1_y), .bike1_orient(bike1_orient), .bike1_color(bike1_color),
        .bike2_x(bike2_x), .bike2_y(bike2_y), .bike2_orient(bike2_orient), .bike2_color(bike2_color),
        .vga_addr(vga_addr), .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .crash1(crash1), .crash2(crash2),
        .game_over(game_over), .winner(winner), .overrun(overrun)
    );

    always #5 clock = ~clock;

    logic [3:0] mem [0:(1<<19)-1];
    always @(posedge clock) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int pcnt = 0;
    always @(posedge clock) pcnt <= pcnt + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int start; int c1; int c2; int go; int win; int ovr; } done_exp_t;
    typedef struct { int addr; int data; } wr_exp_t;
    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];

    // Done monitor: timing at the pulse, sticky status one cycle later.
    always @(negedge clock) begin
        done_exp_t e;
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = done_q.pop_front();
                chk("done_cycle", pcnt - e.start, 12);
                @(negedge clock);
                chk("crash1", int'(crash1), e.c1);
                chk("crash2", int'(crash2), e.c2);
                chk("game_over", int'(game_over), e.go);
                chk("winner", int'(winner), e.win);
                chk("overrun", int'(overrun), e.ovr);
                $display("frame@%0d: crash1=%0d crash2=%0d game_over=%0d winner=%0d overrun=%0d",
                         e.start, crash1, crash2, game_over, winner, overrun);
            end
        end
    end

    // Write monitor: every RAM write must match the next queued stamp.
    always @(negedge clock) begin
        wr_exp_t w;
        if (ram_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", int'(ram_addr), -1);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", int'(ram_addr), w.addr);
                chk("wr_data", int'(ram_wdata), w.data);
                $display("write: addr=%0d data=%0d", ram_addr, ram_wdata);
            end
        end
    end

    task automatic set_bikes(input int x1, input int y1, input int o1,
                             input int x2, input int y2, input int o2);
        bike1_x = 10'(x1); bike1_y = 9'(y1); bike1_orient = 2'(o1);
        bike2_x = 10'(x2); bike2_y = 9'(y2); bike2_orient = 2'(o2);
    endtask

    task automatic push_done(input int s, input int c1, input int c2, input int go,
                             input int win, input int ovr);
        done_exp_t e;
        e.start = s; e.c1 = c1; e.c2 = c2; e.go = go; e.win = win; e.ovr = ovr;
        done_q.push_back(e);
    endtask

    task automatic push_wr(input int a, input int d);
        wr_exp_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    // Called on a negedge; returns on the negedge of cycle +1.
    task automatic fire();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic pulse_new_round();
        new_round = 1'b1;
        @(negedge clock);
        new_round = 1'b0;
    endtask

    int s;
    int probe_exp [4];

    initial begin
        for (int i = 0; i < (1<<19); i++) mem[i] = 4'd0;
        reset = 1'b1; frame_start = 1'b0; new_round = 1'b0;
        bike1_color = 4'd9; bike2_color = 4'd5;
        vga_addr = 19'd12345;
        set_bikes(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_flags", int'({crash1, crash2, game_over, overrun}), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_addr_mux", int'(ram_addr), 12345);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        // 1: empty RAM, no crash; probe addresses and busy window
        set_bikes(320, 240, 0, 100, 100, 3);
        probe_exp[0] = 143675; probe_exp[1] = 143685;
        probe_exp[2] = 60916;  probe_exp[3] = 67316;
        s = pcnt;
        push_done(s, 0, 0, 0, 0, 0);
        push_wr(153920, 9);
        push_wr(64100, 5);
        fire();
        for (int k = 1; k <= 12; k++) begin
            chk("t1_busy", int'(busy), 1);
            if (k == 2 || k == 4 || k == 6 || k == 8)
                chk("t1_probe_addr", int'(ram_addr), probe_exp[k/2-1]);
            @(negedge clock);
        end
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_mem_b1", int'(mem[153920]), 9);
        chk("t1_mem_b2", int'(mem[64100]), 5);

        // 2: trail pixel under bike 1's right probe
        mem[143685] = 4'd3;
        mem[153920] = 4'd0;
        s = pcnt;
        push_done(s, 1, 0, 1, 2, 0);
        push_wr(64100, 5);
        fire();
        repeat (12) @(negedge clock);
        chk("t2_b1_not_stamped", int'(mem[153920]), 0);

        // frame_start while game_over is ignored
        fire();
        for (int k = 1; k <= 3; k++) begin
            chk("go_ignore_busy", int'(busy), 0);
            @(negedge clock);
        end
        chk("go_ignore_overrun", int'(overrun), 0);
        pulse_new_round();
        chk("nr_game_over", int'(game_over), 0);
        chk("nr_winner", int'(winner), 0);
        chk("nr_crash1", int'(crash1), 0);

        // 3: both bikes probe past the screen edge
        set_bikes(320, 10, 0, 3, 200, 1);
        s = pcnt;
        push_done(s, 1, 1, 1, 0, 0);
        fire();
        repeat (12) @(negedge clock);
        pulse_new_round();

        // 4: second frame_start mid-sequence
        set_bikes(200, 300, 2, 400, 50, 1);
        s = pcnt;
        push_done(s, 0, 0, 0, 0, 1);
        push_wr(192200, 9);
        push_wr(32400, 5);
        fire();
        repeat (4) @(negedge clock);
        fire();
        repeat (7) @(negedge clock);
        chk("t4_no_restart", int'(busy), 0);

        // 5: reset during WR2
        set_bikes(50, 400, 3, 600, 300, 0);
        vga_addr = 19'd777;
        push_wr(256050, 9);
        fire();
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("t5_we_gated", int'(ram_we), 0);
        @(negedge clock);
        chk("t5_busy", int'(busy), 0);
        chk("t5_we", int'(ram_we), 0);
        chk("t5_flags", int'({crash1, crash2, game_over, overrun}), 0);
        chk("t5_addr_mux", int'(ram_addr), 777);
        chk("t5_no_partial", int'(mem[192600]), 0);
        chk("t5_wr1_done", int'(mem[256050]), 9);
        reset = 1'b0;
        @(negedge clock);

        // 6: new_round coincides with a crash-setting DONE
        set_bikes(320, 10, 0, 100, 100, 3);
        s = pcnt;
        push_done(s, 0, 0, 0, 0, 0);
        push_wr(64100, 5);
        fire();
        repeat (11) @(negedge clock);
        chk("t6_crash1_pre", int'(crash1), 1);
        pulse_new_round();

        repeat (3) @(negedge clock);
        chk("done_q_empty", done_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
